// File: rtl/pattern_count_engine.sv
// pattern_count_engine: scans a memory range and counts words/offsets matching a pattern
module pattern_count_engine #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [PAT_W-1:0]  pattern,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [31:0] MAX = 32'((64'd1 << CNT_W) - 1);
  state_t            state;
  logic              mode_q;
  logic              vld;
  logic [PAT_W-1:0]  pat_q;
  logic [ADDR_W:0]   rem;
  logic [31:0]       hits;
  logic [31:0]       inc;
  logic [31:0]       sum;
  assign busy = state != IDLE;
  // match count of the returning word and the saturating running total
  always_comb begin
    hits = '0;
    for (int k = 0; k <= DATA_W - PAT_W; k++) hits = hits + 32'(mem_rdata[k +: PAT_W] == pat_q);
    inc = mode_q ? hits : 32'(hits != 0);
    sum = 32'(count) + inc;
  end
  // scan sequencer; vld marks the cycle in which read data returns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      done     <= 1'b0;
      count    <= '0;
      mode_q   <= 1'b0;
      pat_q    <= '0;
      rem      <= '0;
      vld      <= 1'b0;
    end else begin
      vld  <= mem_rd;
      done <= 1'b0;
      if (vld && (state == READ || state == DRAIN)) count <= sum > MAX ? CNT_W'(MAX) : CNT_W'(sum);
      case (state)
        IDLE: if (start) begin
          state    <= READ;
          mode_q   <= mode;
          pat_q    <= pattern;
          rem      <= len;
          mem_addr <= base_addr;
          mem_rd   <= len != 0;
          count    <= '0;
        end
        READ: if (rem <= 1) begin
          state  <= DRAIN;
          mem_rd <= 1'b0;
        end else begin
          rem      <= rem - 1'b1;
          mem_addr <= mem_addr + 1'b1;
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: vector table, directed corner cases and random scans against a reference model
module tb_pattern_count_engine;
  logic       clk = 0, reset = 1, start = 0, mode = 0;
  logic [7:0] base_addr = 0;
  logic [8:0] len = 0;
  logic [3:0] pattern = 0;
  logic       mem_rd, busy, done;
  logic [7:0] mem_addr, count;
  logic [7:0] mem_rdata = 0;
  logic [7:0] mem [256];
  int tests = 0, fails = 0;
  int r_done, r_nrd, r_first, r_last, r_busy_after, r_hold, r_count;
  int addrs[$];

  typedef struct {bit m; logic [3:0] p; logic [7:0] w; int exp;} vec_t;
  vec_t vecs [12] = '{
    '{1'b0, 4'hD, 8'h6D, 1}, '{1'b1, 4'hD, 8'h6D, 2}, '{1'b0, 4'hF, 8'hFF, 1},
    '{1'b1, 4'hF, 8'hFF, 5}, '{1'b1, 4'h0, 8'h00, 5}, '{1'b0, 4'hA, 8'hAA, 1},
    '{1'b1, 4'hA, 8'hAA, 3}, '{1'b1, 4'h3, 8'h00, 0}, '{1'b0, 4'h3, 8'h00, 0},
    '{1'b1, 4'h5, 8'h55, 3}, '{1'b1, 4'h1, 8'h11, 2}, '{1'b0, 4'h8, 8'h80, 1}
  };

  pattern_count_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .len(len), .pattern(pattern), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: count matches per word from the rules, saturating at 255
  function automatic int ref_count(bit m, logic [3:0] p, int base, int n);
    int total = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] w = mem[(base + i) % 256];
      int h = 0;
      for (int k = 0; k <= 4; k++) if (((w >> k) & 8'hF) == 8'(p)) h++;
      total += m ? h : int'(h > 0);
      if (total > 255) total = 255;
    end
    return total;
  endfunction

  task automatic zero_outputs(string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  // start a scan, scramble the inputs right after acceptance, record the observed behaviour
  task automatic scan(bit m, logic [7:0] b, logic [8:0] n, logic [3:0] p, bit hold);
    @(negedge clk);
    mode = m; base_addr = b; len = n; pattern = p; start = 1;
    @(posedge clk);
    #1 start = hold; mode = ~m; base_addr = ~b; pattern = ~p; len = 9'(n + 3);
    addrs.delete();
    r_done = -1; r_nrd = 0; r_first = -1; r_last = -1; r_count = -1;
    for (int c = 1; c <= int'(n) + 10; c++) begin
      @(negedge clk);
      if (mem_rd) begin
        r_nrd++;
        addrs.push_back(int'(mem_addr));
        if (r_first < 0) r_first = c;
        r_last = c;
      end
      if (done) begin
        r_done = c;
        r_count = int'(count);
        break;
      end
    end
    @(negedge clk);
    r_busy_after = busy;
    r_hold = int'(count);
    start = 0;
  endtask

  initial begin
    int seen_done, b, exp;
    logic [3:0] p;
    bit m;
    for (int i = 0; i < 256; i++) mem[i] = 0;
    #1 reset = 0;
    #1 zero_outputs("reset");
    @(negedge clk) reset = 1;

    for (int i = 0; i < 12; i++) begin
      mem[0] = vecs[i].w;
      scan(vecs[i].m, 8'h00, 9'd1, vecs[i].p, 1'b0);
      chk($sformatf("vec%0d_count", i), r_count, vecs[i].exp);
      chk($sformatf("vec%0d_done_cycle", i), r_done, 3);
    end

    mem[8'hFE] = 8'h0F; mem[8'hFF] = 8'hF0; mem[8'h00] = 8'h3C; mem[8'h01] = 8'h55;
    scan(1'b1, 8'hFE, 9'd4, 4'hF, 1'b0);
    chk("wrap_nrd", r_nrd, 4);
    if (addrs.size() == 4) begin
      chk("wrap_addr0", addrs[0], 8'hFE);
      chk("wrap_addr1", addrs[1], 8'hFF);
      chk("wrap_addr2", addrs[2], 8'h00);
      chk("wrap_addr3", addrs[3], 8'h01);
    end
    chk("wrap_first_rd", r_first, 1);
    chk("wrap_last_rd", r_last, 4);
    chk("wrap_done_cycle", r_done, 6);
    chk("wrap_count", r_count, 3);

    scan(1'b1, 8'h10, 9'd0, 4'h0, 1'b0);
    chk("len0_nrd", r_nrd, 0);
    chk("len0_done_cycle", r_done, 3);
    chk("len0_count", r_count, 0);

    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    scan(1'b1, 8'h00, 9'd64, 4'hF, 1'b0);
    chk("sat_count", r_count, 255);
    chk("sat_done_cycle", r_done, 66);
    chk("sat_hold", r_hold, 255);

    for (int i = 0; i < 10; i++) mem[8'h20 + i] = 8'($urandom);
    exp = ref_count(1'b1, 4'h6, 8'h20, 10);
    scan(1'b1, 8'h20, 9'd10, 4'h6, 1'b1);
    chk("hold_done_cycle", r_done, 12);
    chk("hold_count", r_count, exp);
    chk("hold_no_restart", r_busy_after, 0);
    chk("hold_count_stable", r_hold, exp);

    @(negedge clk);
    mode = 0; base_addr = 8'h40; len = 9'd20; pattern = 4'h1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    chk("midscan_busy_before_reset", busy, 1);
    #2 reset = 0;
    #1 zero_outputs("async_reset");
    seen_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < 5; i++) mem[8'h40 + i] = 8'($urandom);
    exp = ref_count(1'b0, 4'h1, 8'h40, 5);
    scan(1'b0, 8'h40, 9'd5, 4'h1, 1'b0);
    chk("after_reset_done_cycle", r_done, 7);
    chk("after_reset_count", r_count, exp);

    for (int t = 0; t < 6; t++) begin
      b = int'($urandom_range(0, 255));
      p = 4'($urandom);
      m = 1'($urandom);
      for (int i = 0; i < 64; i++) mem[(b + i) % 256] = 8'($urandom);
      exp = ref_count(m, p, b, 64);
      scan(m, 8'(b), 9'd64, p, 1'b0);
      chk($sformatf("rand%0d_count", t), r_count, exp);
      chk($sformatf("rand%0d_done_cycle", t), r_done, 66);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pattern_count_engine.md
PATTERN_COUNT_ENGINE -- requirements
Module: pattern_count_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, memory word width.
- PAT_W, 4, pattern width; legal range 1..DATA_W.
- ADDR_W, 8, data-memory address width.
- CNT_W, 8, result counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, request a scan; sampled only in IDLE.
- mode, in, 1, 0 = count matching words, 1 = count total match occurrences.
- base_addr, in, ADDR_W, first word address.
- len, in, ADDR_W+1, number of words to scan, 0..2^ADDR_W.
- pattern, in, PAT_W, search pattern.
- mem_rd, out, 1, memory read strobe.
- mem_addr, out, ADDR_W, memory read address.
- mem_rdata, in, DATA_W, read data, valid exactly 1 cycle after a mem_rd cycle.
- busy, out, 1, high whenever state is not IDLE.
- done, out, 1, one-cycle completion pulse.
- count, out, CNT_W, result; held stable from the done cycle until the next accepted start.

Function
REQ-003 States SHALL be IDLE, READ, DRAIN and DONE, with transitions IDLE->READ on start, READ->DRAIN after len read cycles, DRAIN->DONE, and DONE->IDLE.
REQ-004 On the edge where start=1 in IDLE, the block SHALL latch mode, base_addr, len and pattern, clear count to 0, and enter READ; input changes after that edge SHALL have no effect on the scan.
REQ-005 In READ, mem_rd SHALL be 1 for exactly len consecutive cycles, with mem_addr = base_addr + i (i = 0..len-1) modulo 2^ADDR_W, so the address wraps from 2^ADDR_W-1 to 0.
REQ-006 Each mem_rdata word SHALL be evaluated at the DATA_W-PAT_W+1 offsets k, comparing word[k+PAT_W-1:k] with the latched pattern.
REQ-007 In mode 0 the block SHALL add 1 per word with at least one matching offset; in mode 1 it SHALL add the number of matching offsets.
REQ-008 Accumulation SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-009 The data for the last read SHALL be accumulated during DRAIN, and done SHALL be 1 only in the DONE cycle, which is cycle len+2 after the start edge (start edge = cycle 0).
REQ-010 For len=0 the block SHALL issue no mem_rd, SHALL go READ->DRAIN after one cycle, and SHALL pulse done with count=0 at cycle 3.
REQ-011 start asserted while busy=1, including in the DONE cycle, SHALL be ignored and not queued.
REQ-012 mem_rd SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-013 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, mem_rd=0, mem_addr=0, busy=0, done=0 and count=0.
REQ-014 A reset asserted mid-scan SHALL abort the scan, produce no done pulse, and leave the block accepting start on the first edge after reset is released.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Defaults, pattern=4'b1101, len=1, word 0x6D, mode 0 -> count=1; mode 1 -> count=2; done exactly at cycle 3.
- base_addr=0xFE, len=4 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; mem_rd high cycles 1-4; done at cycle 6.
- len=0 -> no mem_rd; done at cycle 3 with count=0.
- mode 1, pattern=4'hF, 64 words of 0xFF -> count saturates at 255, not 64 (320 mod 256).
- start pulsed during READ and during DONE -> no restart; count and done timing unchanged.
- reset=0 asserted at cycle 5 of a len=20 scan -> outputs zero asynchronously, no done; a new start scans correctly.
- Random regression: 64 random words, random pattern and mode, compared against a bench reference model.
